// File: rtl/sha_msg_scheduler.sv
// SHA-256/512 message scheduler: expands a 16-word block into ROUNDS schedule words Wt.
// Optional round-index port t_o is enabled by defining SHA_SCHED_ROUND_IDX_EN.
module sha_msg_scheduler #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [16*WORD_W-1:0]   m_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [WORD_W-1:0]      wt_o,
  output logic                   v_o,
  input  logic                   ready_i,
  output logic                   last_o
`ifdef SHA_SCHED_ROUND_IDX_EN
  ,
  output logic [$clog2(ROUNDS)-1:0] t_o
`endif
);

  localparam int unsigned TW = $clog2(ROUNDS);
  localparam logic [TW-1:0] T_LAST = TW'(ROUNDS - 1);
  localparam logic [TW-1:0] T_WIN  = TW'(16);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  // Only the two standard SHA-2 geometries are supported
  generate
    if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
      $error("sha_msg_scheduler: illegal WORD_W/ROUNDS combination");
    end
  endgenerate

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  state_e              state_q;
  logic [TW-1:0]       t_q;
  logic [WORD_W-1:0]   win_q [16];
  logic [WORD_W-1:0]   w_new;
  logic                in_hs;
  logic                out_hs;

  // Next schedule word from the sliding window (win_q[0] is W(t-16))
  always_comb begin
    w_new = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
  end

  assign v_o     = (state_q == BUSY);
  assign last_o  = (state_q == BUSY) && (t_q == T_LAST);
  assign ready_o = !reset_i && ((state_q == IDLE) || (last_o && ready_i));
  assign wt_o    = (state_q != BUSY) ? '0 : ((t_q < T_WIN) ? win_q[t_q[3:0]] : w_new);
  assign in_hs   = v_i & ready_o;
  assign out_hs  = v_o & ready_i;

`ifdef SHA_SCHED_ROUND_IDX_EN
  assign t_o = t_q;
`endif

  // Control FSM and window; a load on the final handshake overrides the return to IDLE
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      if (out_hs) begin
        if (t_q >= T_WIN) begin
          for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
          win_q[15] <= w_new;
        end
        if (t_q != T_LAST) begin
          t_q <= t_q + TW'(1);
        end else begin
          t_q     <= '0;
          state_q <= IDLE;
        end
      end
      if (in_hs) begin
        for (int i = 0; i < 16; i++) win_q[i] <= m_i[(16-i)*WORD_W-1 -: WORD_W];
        t_q     <= '0;
        state_q <= BUSY;
      end
    end
  end

endmodule

// File: tb/tb_sha_msg_scheduler.sv
// Scoreboard bench for sha_msg_scheduler: SHA-256 and SHA-512 instances with directed blocks.
module tb_sha_msg_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_i;
  logic [511:0]   m_i;
  logic           v_i, ready_o, v_o, ready_i, last_o;
  logic [31:0]    wt_o;
  logic [1023:0]  m64_i;
  logic           v64_i, ready64_o, v64_o, ready64_i, last64_o;
  logic [63:0]    wt64_o;
`ifdef SHA_SCHED_ROUND_IDX_EN
  logic [5:0]     t_o;
  logic [6:0]     t64_o;
`endif

  sha_msg_scheduler #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk_i(clk), .reset_i(reset_i), .m_i(m_i), .v_i(v_i), .ready_o(ready_o),
    .wt_o(wt_o), .v_o(v_o), .ready_i(ready_i), .last_o(last_o)
`ifdef SHA_SCHED_ROUND_IDX_EN
    , .t_o(t_o)
`endif
  );

  sha_msg_scheduler #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk_i(clk), .reset_i(reset_i), .m_i(m64_i), .v_i(v64_i), .ready_o(ready64_o),
    .wt_o(wt64_o), .v_o(v64_o), .ready_i(ready64_i), .last_o(last64_o)
`ifdef SHA_SCHED_ROUND_IDX_EN
    , .t_o(t64_o)
`endif
  );

  typedef struct packed {
    logic [63:0] w;
    logic        last;
    logic [7:0]  t;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int checks = 0;
  int errors = 0;
  int n_hs = 0;
  int run = 0;
  int max_run = 0;

  logic [31:0] w32m [64];
  logic [63:0] w64m [80];

  localparam logic [511:0]  ABC32 = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [1023:0] ABC64 = {64'h6162638000000000, 896'h0, 64'h18};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
  endfunction

  // Reference schedule expansion W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  task automatic model32(input logic [511:0] m);
    for (int t = 0; t < 16; t++) w32m[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w32m[t] = s1_32(w32m[t-2]) + w32m[t-7] + s0_32(w32m[t-15]) + w32m[t-16];
  endtask

  task automatic model64(input logic [1023:0] m);
    for (int t = 0; t < 16; t++) w64m[t] = m[1023-64*t -: 64];
    for (int t = 16; t < 80; t++)
      w64m[t] = s1_64(w64m[t-2]) + w64m[t-7] + s0_64(w64m[t-15]) + w64m[t-16];
  endtask

  // Present a block; push the expected stream once the scheduler is ready to take it
  task automatic send32(input logic [511:0] m, input bit hold);
    int k;
    m_i = m;
    v_i = 1'b1;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ready_o) break;
    end
    if (k == 400) begin
      checks++; errors++;
      $display("FAIL send32_ready_timeout: got ready_o=0 expected 1 within 400 cycles");
      v_i = 1'b0;
      return;
    end
    for (int i = 0; i < 64; i++) q32.push_back('{w: 64'(w32m[i]), last: 1'(i == 63), t: 8'(i)});
    @(posedge clk); #1;
    if (!hold) v_i = 1'b0;
  endtask

  task automatic send64(input logic [1023:0] m);
    int k;
    m64_i = m;
    v64_i = 1'b1;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ready64_o) break;
    end
    if (k == 400) begin
      checks++; errors++;
      $display("FAIL send64_ready_timeout: got ready_o=0 expected 1 within 400 cycles");
      v64_i = 1'b0;
      return;
    end
    for (int i = 0; i < 80; i++) q64.push_back('{w: w64m[i], last: 1'(i == 79), t: 8'(i)});
    @(posedge clk); #1;
    v64_i = 1'b0;
  endtask

  task automatic wait_empty();
    int k;
    for (k = 0; k < 600; k++) begin
      if (q32.size() == 0 && q64.size() == 0) break;
      @(negedge clk);
    end
    if (k == 600) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q32.size(), q64.size());
    end
    @(negedge clk);
    chk("idle_v_o", 64'(v_o), 64'd0);
    chk("idle_ready_o", 64'(ready_o), 64'd1);
    chk("idle_v64_o", 64'(v64_o), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int base, input int n);
    int k;
    for (k = 0; k < 300; k++) begin
      if (n_hs - base >= n) break;
      @(posedge clk); #1;
    end
    if (k == 300) begin
      checks++; errors++;
      $display("FAIL hs_timeout: got %0d handshakes expected %0d", n_hs - base, n);
    end
  endtask

  // 32-bit monitor: compares on each handshake, and checks output stability under stall
  always @(negedge clk) begin
    exp_t e;
    if (v_o === 1'b1) run++;
    else run = 0;
    if (run > max_run) max_run = run;
    if (v_o === 1'b1 && ready_i) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL wt32_unexpected: got %h expected no output", wt_o);
      end else begin
        e = q32.pop_front();
        chk($sformatf("wt32[%0d]", e.t), 64'(wt_o), e.w);
        chk($sformatf("last32[%0d]", e.t), 64'(last_o), 64'(e.last));
`ifdef SHA_SCHED_ROUND_IDX_EN
        chk($sformatf("t32[%0d]", e.t), 64'(t_o), 64'(e.t));
`endif
        n_hs++;
      end
    end else if (v_o === 1'b1 && q32.size() > 0) begin
      e = q32[0];
      chk($sformatf("stall_wt32[%0d]", e.t), 64'(wt_o), e.w);
      chk($sformatf("stall_last32[%0d]", e.t), 64'(last_o), 64'(e.last));
`ifdef SHA_SCHED_ROUND_IDX_EN
      chk($sformatf("stall_t32[%0d]", e.t), 64'(t_o), 64'(e.t));
`endif
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (v64_o === 1'b1 && ready64_i) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL wt64_unexpected: got %h expected no output", wt64_o);
      end else begin
        e = q64.pop_front();
        chk($sformatf("wt64[%0d]", e.t), wt64_o, e.w);
        chk($sformatf("last64[%0d]", e.t), 64'(last64_o), 64'(e.last));
`ifdef SHA_SCHED_ROUND_IDX_EN
        chk($sformatf("t64[%0d]", e.t), 64'(t64_o), 64'(e.t));
`endif
      end
    end
  end

  initial begin
    logic [511:0] blk2;
    int base;
    for (int i = 0; i < 16; i++) blk2[511-32*i -: 32] = 32'h9e3779b9 * 32'(i + 1);
    reset_i = 1'b1; v_i = 1'b0; m_i = '0; ready_i = 1'b1;
    v64_i = 1'b0; m64_i = '0; ready64_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd0);
    chk("rst_wt_o", 64'(wt_o), 64'd0);
    chk("rst_last_o", 64'(last_o), 64'd0);
    chk("rst_v64_o", 64'(v64_o), 64'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_o", 64'(ready_o), 64'd1);
    chk("post_rst_ready64_o", 64'(ready64_o), 64'd1);
    @(posedge clk); #1;

    // Padded "abc", with hand-computed W16..W19
    model32(ABC32);
    w32m[16] = 32'h61626380;
    w32m[17] = 32'h000F0000;
    w32m[18] = 32'h7DA86405;
    w32m[19] = 32'h600003C6;
    send32(ABC32, 1'b0);
    wait_empty();

    // Backpressure at t=20 for 5 cycles
    model32(blk2);
    base = n_hs;
    send32(blk2, 1'b0);
    wait_hs(base, 20);
    ready_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 ready_i = 1'b1;
    wait_empty();

    // Two chained blocks with v_i held high: no bubble between them
    max_run = 0;
    model32(ABC32);
    send32(ABC32, 1'b1);
    model32('1);
    send32('1, 1'b0);
    wait_empty();
    chk("chain_run_len", 64'(max_run), 64'd128);

    // Reset at t=30 abandons the block; a new block restarts at W0
    model32(blk2);
    base = n_hs;
    send32(blk2, 1'b0);
    wait_hs(base, 30);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    q32.delete();
    @(negedge clk);
    chk("midrst_v_o", 64'(v_o), 64'd0);
    chk("midrst_last_o", 64'(last_o), 64'd0);
    chk("midrst_ready_o", 64'(ready_o), 64'd1);
`ifdef SHA_SCHED_ROUND_IDX_EN
    chk("midrst_t_o", 64'(t_o), 64'd0);
`endif
    @(posedge clk); #1;
    model32(ABC32);
    send32(ABC32, 1'b0);
    wait_empty();

    // SHA-512 geometry, padded "abc"
    model64(ABC64);
    send64(ABC64);
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
